serial_ripple_adder: RTL

//   Bit-serial adder built around one full-adder cell. Adds two WIDTH-bit operands

---
 rtl/serial_ripple_adder.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/serial_ripple_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_ripple_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADD_OVF_EN
   ,output logic            ovf
`endif
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned ACC_W = WIDTH - 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   sa_q, sa_d;
   logic [WIDTH-1:0]   sb_q, sb_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic               carry_q, carry_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               cout_q, cout_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               s_c;
   logic               c_c;
   logic               last_bit_c;

   // The single full-adder cell
   assign s_c        = sa_q[0] ^ sb_q[0] ^ carry_q;
   assign c_c        = (sa_q[0] & sb_q[0]) | (sa_q[0] & carry_q) | (sb_q[0] & carry_q);
   assign last_bit_c = (cnt_q == CNT_W'(WIDTH - 1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start)      state_d = S_RUN;
         S_RUN:   if (last_bit_c) state_d = S_DONE;
         S_DONE:                  state_d = S_IDLE;
         default:                 state_d = S_IDLE;
      endcase
   end

   // Status outputs, registered from the next state
   always_comb begin
      busy_d = 1'b0;
      done_d = 1'b0;
      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   assign ready = (state_q == S_IDLE);
   assign busy  = busy_q;
   assign done  = done_q;
   assign sum   = sum_q;
   assign cout  = cout_q;

`ifdef SERIAL_ADD_OVF_EN
   logic ovf_q, ovf_d;
   assign ovf = ovf_q;
`endif

   // Datapath: operand load, bit-serial shift, result capture
   always_comb begin
      sa_d    = sa_q;
      sb_d    = sb_q;
      acc_d   = acc_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               sa_d    = a;
               sb_d    = b;
               carry_d = cin;
               acc_d   = '0;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            carry_d = c_c;
            sa_d    = sa_q >> 1;
            sb_d    = sb_q >> 1;
            acc_d   = ACC_W'({s_c, acc_q} >> 1);
            cnt_d   = cnt_q + CNT_W'(1);
            if (last_bit_c) begin
               sum_d  = {s_c, acc_q};
               cout_d = c_c;
               cnt_d  = '0;
`ifdef SERIAL_ADD_OVF_EN
               // carry_q here is the carry into the MSB
               ovf_d  = carry_q ^ c_c;
`endif
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sa_q    <= '0;
         sb_q    <= '0;
         acc_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         acc_q   <= acc_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef SERIAL_ADD_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

endmodule
